// File: rtl/aes_pkg.sv
// Shared AES helpers: GF(2^8) doubling/tripling, the reduction constant and the
// FSM state encoding used by the serial MixColumns block.
package aes_pkg;

    localparam logic [7:0] AES_POLY = 8'h1B;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } fsm_state_t;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? AES_POLY : 8'h00);
    endfunction

    function automatic logic [7:0] gmul2(input logic [7:0] a);
        return xtime(a);
    endfunction

    function automatic logic [7:0] gmul3(input logic [7:0] a);
        return xtime(a) ^ a;
    endfunction

endpackage

// File: rtl/mix_column_one.sv
// Forward AES MixColumns for a single 32-bit column (row 0 in the top byte).
module mix_column_one
    import aes_pkg::*;
(
    input  logic [31:0] col_in,
    output logic [31:0] col_out
);

    logic [7:0] a0, a1, a2, a3;

    assign a0 = col_in[31:24];
    assign a1 = col_in[23:16];
    assign a2 = col_in[15:8];
    assign a3 = col_in[7:0];

    assign col_out[31:24] = gmul2(a0) ^ gmul3(a1) ^ a2 ^ a3;
    assign col_out[23:16] = a0 ^ gmul2(a1) ^ gmul3(a2) ^ a3;
    assign col_out[15:8]  = a0 ^ a1 ^ gmul2(a2) ^ gmul3(a3);
    assign col_out[7:0]   = gmul3(a0) ^ a1 ^ a2 ^ gmul2(a3);

endmodule

// File: rtl/mix_columns_serial.sv
// Serial AES MixColumns: one column per cycle through a single column datapath.
// Define MIX_COLUMNS_BYPASS_EN to add final_round, which passes columns through unchanged.
module mix_columns_serial
    import aes_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] state_in,
`ifdef MIX_COLUMNS_BYPASS_EN
    input  logic         final_round,
`endif
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] state_out,
    output fsm_state_t   state_dbg
);

    // Handshake: a transfer happens on a rising clk edge where valid and ready are both high.
    fsm_state_t   state_q, state_d;
    logic [1:0]   col_idx;
    logic [127:0] in_reg;
    logic [127:0] out_reg;
    logic [31:0]  col_sel;
    logic [31:0]  col_mixed;
    logic [31:0]  col_res;
    logic         accept;

    assign in_ready  = (state_q == IDLE) | ((state_q == DONE) & out_ready);
    assign accept    = in_valid & in_ready;
    assign out_valid = (state_q == DONE);
    assign state_out = out_reg;
    assign state_dbg = state_q;

    always_comb begin
        col_sel = in_reg[127:96];
        case (col_idx)
            2'd0: col_sel = in_reg[127:96];
            2'd1: col_sel = in_reg[95:64];
            2'd2: col_sel = in_reg[63:32];
            2'd3: col_sel = in_reg[31:0];
            default: col_sel = in_reg[127:96];
        endcase
    end

    mix_column_one u_col (
        .col_in  (col_sel),
        .col_out (col_mixed)
    );

`ifdef MIX_COLUMNS_BYPASS_EN
    logic bypass_q;
    assign col_res = bypass_q ? col_sel : col_mixed;
`else
    assign col_res = col_mixed;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (accept) state_d = BUSY;
            BUSY: if (col_idx == 2'd3) state_d = DONE;
            // Output handshake and a fresh accept may share the same edge.
            DONE: if (out_ready) state_d = in_valid ? BUSY : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            col_idx <= 2'd0;
            in_reg  <= 128'h0;
            out_reg <= 128'h0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                in_reg  <= state_in;
                col_idx <= 2'd0;
            end else if (state_q == BUSY) begin
                case (col_idx)
                    2'd0: out_reg[127:96] <= col_res;
                    2'd1: out_reg[95:64]  <= col_res;
                    2'd2: out_reg[63:32]  <= col_res;
                    2'd3: out_reg[31:0]   <= col_res;
                    default: out_reg[127:96] <= col_res;
                endcase
                col_idx <= col_idx + 2'd1;
            end
        end
    end

`ifdef MIX_COLUMNS_BYPASS_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bypass_q <= 1'b0;
        end else if (accept) begin
            bypass_q <= final_round;
        end
    end
`endif

endmodule

// File: tb/tb_mix_columns_serial.sv
// Scoreboard bench for mix_columns_serial: driver pushes expected blocks, monitor pops on output.
module tb_mix_columns_serial;
  import aes_pkg::*;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] state_in;
  logic         final_round;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] state_out;
  fsm_state_t   state_dbg;

  logic [127:0] exp_q[$];
  int           acc_q[$];
  int           cyc = 0;
  int           n_checks = 0;
  int           n_pass = 0;
  logic         rand_ready = 1'b0;
  logic         seen_valid = 1'b0;
  logic [127:0] held;

  mix_columns_serial dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .state_in    (state_in),
`ifdef MIX_COLUMNS_BYPASS_EN
    .final_round (final_round),
`endif
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .state_out   (state_out),
    .state_dbg   (state_dbg)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // reference model: GF(2^8) product by shift-and-add, matrix rows are rotations of {2,3,1,1}
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    logic [7:0] y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [127:0] mix_ref(input logic [127:0] s, input logic fr);
    logic [7:0]   coef[4] = '{8'd2, 8'd3, 8'd1, 8'd1};
    logic [127:0] r = 128'h0;
    logic [7:0]   acc;
    if (fr) return s;
    for (int c = 0; c < 4; c++) begin
      for (int row = 0; row < 4; row++) begin
        acc = 8'h00;
        for (int j = 0; j < 4; j++)
          acc = acc ^ gf_mul(coef[(j - row) & 3], s[127 - 32*c - 8*j -: 8]);
        r[127 - 32*c - 8*row -: 8] = acc;
      end
    end
    return r;
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    $display("FAIL %s: got timeout/unexpected event, expected none", name);
  endtask

  // driver: present a block, wait (bounded) for accept, then scramble inputs while busy
  task automatic send(input logic [127:0] d, input logic [127:0] exp, input logic fr,
                      output int acc_at, output int waits);
    in_valid = 1'b1;
    state_in = d;
    final_round = fr;
    waits = 0;
    acc_at = -1;
    #1;
    while (!in_ready && waits < 200) begin
      @(negedge clk); #1;
      waits++;
    end
    if (!in_ready) begin
      fail_now("accept_timeout");
      in_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    acc_at = cyc;
    exp_q.push_back(exp);
    acc_q.push_back(cyc);
    repeat (4) begin
      @(negedge clk);
      in_valid = 1'($urandom_range(0, 1));
      state_in = {$urandom, $urandom, $urandom, $urandom};
      final_round = 1'($urandom_range(0, 1));
    end
    @(negedge clk);
    in_valid = 1'b0;
    state_in = {$urandom, $urandom, $urandom, $urandom};
  endtask

  // random backpressure source
  initial begin
    forever begin
      @(negedge clk);
      if (rand_ready) out_ready = 1'($urandom_range(0, 1));
    end
  end

  // monitor / scoreboard
  initial begin
    forever begin
      @(negedge clk); #2;
      if (!rst_n) begin
        seen_valid = 1'b0;
      end else if (out_valid) begin
        if (exp_q.size() == 0) begin
          fail_now("unexpected_out_valid");
        end else begin
          if (!seen_valid) begin
            check("state_out", state_out, exp_q[0]);
            check("latency", 128'(cyc - acc_q[0] + 1), 128'd5);
            held = state_out;
            seen_valid = 1'b1;
          end else begin
            check("state_out_stable", state_out, held);
          end
          if (out_ready) begin
            void'(exp_q.pop_front());
            void'(acc_q.pop_front());
            seen_valid = 1'b0;
          end
        end
      end
    end
  end

  initial begin
    int a0, a1, w;
    logic [127:0] d;
    logic fr;
    rst_n = 1'b0; in_valid = 1'b0; state_in = 128'h0; out_ready = 1'b1; final_round = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_out_valid", 128'(out_valid), 128'd0);
    check("reset_state_out", state_out, 128'h0);
    check("reset_in_ready", 128'(in_ready), 128'd1);
    @(negedge clk);
    rst_n = 1'b1;

    // known answers
    send({4{32'hdb135345}}, {4{32'h8e4da1bc}}, 1'b0, a0, w);
    send(128'hd4bf5d30e0b452aeb84111f11e2798e5, 128'h046681e5e0cb199a48f8d37a2806264c, 1'b0, a0, w);
    send(128'hf20a225c01010101c6c6c6c6d4d4d4d5, 128'h9fdc589d01010101c6c6c6c6d5d5d7d6, 1'b0, a0, w);

    // sustained throughput with out_ready held high
    d = {$urandom, $urandom, $urandom, $urandom};
    send(d, mix_ref(d, 1'b0), 1'b0, a0, w);
    for (int i = 0; i < 3; i++) begin
      d = {$urandom, $urandom, $urandom, $urandom};
      send(d, mix_ref(d, 1'b0), 1'b0, a1, w);
      check("accept_interval", 128'(a1 - a0), 128'd5);
      a0 = a1;
    end

    // random blocks under random backpressure
    rand_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      d = {$urandom, $urandom, $urandom, $urandom};
`ifdef MIX_COLUMNS_BYPASS_EN
      fr = 1'($urandom_range(0, 1));
`else
      fr = 1'b0;
`endif
      send(d, mix_ref(d, fr), fr, a0, w);
    end
    rand_ready = 1'b0;
    @(negedge clk); #1;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);

    // hold-off: output stalled for 10 cycles, then handshake and accept on the same edge
    #1;
    out_ready = 1'b0;
    d = {$urandom, $urandom, $urandom, $urandom};
    send(d, mix_ref(d, 1'b0), 1'b0, a0, w);
    repeat (10) begin
      @(negedge clk); #1;
      check("hold_in_ready", 128'(in_ready), 128'd0);
      check("hold_out_valid", 128'(out_valid), 128'd1);
    end
    @(negedge clk); #1;
    out_ready = 1'b1;
    d = {$urandom, $urandom, $urandom, $urandom};
    send(d, mix_ref(d, 1'b0), 1'b0, a0, w);
    check("same_cycle_accept_waits", 128'(w), 128'd0);

    // reset during the second busy cycle aborts the block
    #1;
    in_valid = 1'b1;
    state_in = {$urandom, $urandom, $urandom, $urandom};
    #1;
    check("pre_abort_in_ready", 128'(in_ready), 128'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk); #1;
    check("abort_out_valid", 128'(out_valid), 128'd0);
    check("abort_state_out", state_out, 128'h0);
    check("abort_in_ready", 128'(in_ready), 128'd1);
    repeat (8) @(negedge clk);
    d = {$urandom, $urandom, $urandom, $urandom};
    send(d, mix_ref(d, 1'b0), 1'b0, a0, w);

`ifdef MIX_COLUMNS_BYPASS_EN
    send({4{32'h2d26314c}}, {4{32'h2d26314c}}, 1'b1, a0, w);
`endif

    // drain
    w = 0;
    while (exp_q.size() != 0 && w < 100) begin
      @(negedge clk);
      w++;
    end
    if (exp_q.size() != 0) fail_now("drain_timeout");
    repeat (3) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mix_columns_serial.md
MIX_COLUMNS_SERIAL -- requirements
Module: mix_columns_serial

Interface
REQ-001 SHALL have ports: clk, input, 1, rising-edge clock.
REQ-002 SHALL have ports: rst_n, input, 1, synchronous active-low reset.
REQ-003 SHALL have ports: in_valid, input, 1, state_in holds a block to transform.
REQ-004 SHALL have ports: in_ready, output, 1, block accepted when in_valid and in_ready are both high at a clk edge.
REQ-005 SHALL have ports: state_in, input, 128, AES state; column c = bits [127-32c -: 32]; row byte r of column c = bits [127-32c-8r -: 8].
REQ-006 SHALL have ports: out_valid, output, 1, state_out holds a finished block.
REQ-007 SHALL have ports: out_ready, input, 1, consumer accepts state_out when out_valid and out_ready are both high.
REQ-008 SHALL have ports: state_out, output, 128, forward MixColumns result, same byte layout as state_in.
REQ-009 SHALL provide the final_round port (input, 1, sampled with state_in on accept) only when MIX_COLUMNS_BYPASS_EN is defined.

Function
REQ-010 SHALL implement the forward AES MixColumns (FIPS-197 5.1.3) per column: r0=2a0^3a1^a2^a3, r1=a0^2a1^3a2^a3, r2=a0^a1^2a2^3a3, r3=3a0^a1^a2^2a3, arithmetic in GF(2^8), poly 0x11B.
REQ-011 SHALL implement xtime(a) as (a<<1) truncated to 8 bits, XOR 0x1B when a[7]=1; 3a = xtime(a)^a.
REQ-012 SHALL process one column per cycle through a single column datapath instance, column 0 first.
REQ-013 SHALL use FSM states IDLE, BUSY, DONE.
REQ-014 SHALL transition IDLE->BUSY on accept: latch state_in into the input register and clear col_idx to 0.
REQ-015 SHALL, in BUSY, write the column col_idx result into the output register each cycle and increment col_idx (2 bits); after col_idx=3 the FSM SHALL go to DONE.
REQ-016 SHALL assert out_valid in DONE only; state_out SHALL remain stable while out_valid=1 and out_ready=0.
REQ-017 SHALL assert in_ready = (state==IDLE) | (state==DONE & out_ready), combinationally.
REQ-018 SHALL treat DONE with out_ready=1 and in_valid=1 as a simultaneous output handshake and new accept: next state BUSY with no idle bubble.
REQ-019 SHALL go DONE->IDLE on out_ready=1 with in_valid=0.
REQ-020 SHALL have latency of 5 clk edges from the accept edge to out_valid high (1 latch + 4 column cycles), and a throughput of 1 block per 5 cycles sustained.
REQ-021 SHALL ignore in_valid and state_in while BUSY; state_in changes there SHALL not affect the result.

Reset
REQ-022 SHALL, while rst_n=0 at a clk edge, set state=IDLE, col_idx=0, out_valid=0, state_out=128'h0, input register=0; in_ready SHALL be 1 in the first cycle after reset.
REQ-023 SHALL abort any in-flight block on reset mid-BUSY or mid-DONE with no output handshake, and SHALL NOT produce partial results afterwards.

Configuration
REQ-024 SHALL, with MIX_COLUMNS_BYPASS_EN defined, pass columns through unchanged for a block accepted with final_round=1 (AES last round), with identical latency and handshake.
REQ-025 SHALL, without MIX_COLUMNS_BYPASS_EN, have no final_round port and always transform.

Structure
REQ-026 SHALL take xtime/gmul2/gmul3 helper functions, the constant 8'h1B, and the FSM state encodings from the shared package aes_pkg.
REQ-027 SHALL place the per-column combinational math in sub-module mix_column_one (32-bit in, 32-bit out), instantiated once.

Verification
REQ-028 SHALL verify the column db 13 53 45 placed in all four columns -> out_valid on the 5th edge, every column equal to 8e 4d a1 bc.
REQ-029 SHALL verify the FIPS-197 App. B round 1 input d4bf5d30e0b452aeb84111f11e2798e5 -> 046681e5e0cb199a48f8d37a2806264c.
REQ-030 SHALL verify the columns f20a225c, 01010101, c6c6c6c6, d4d4d4d5 -> 9fdc589d, 01010101, c6c6c6c6, d5d5d7d6.
REQ-031 SHALL verify that holding out_ready=0 for 10 cycles keeps state_out stable and in_ready=0; then, with out_ready=1 and in_valid=1 together, the next block is accepted in the same cycle and its result appears 5 edges later.
REQ-032 SHALL verify that rst_n=0 asserted at BUSY cycle 2 gives out_valid=0, state_out=0, in_ready=1 next cycle, and that a following block gives the correct result.
REQ-033 SHALL verify, with MIX_COLUMNS_BYPASS_EN and final_round=1, that input 2d26314c repeated -> output identical to input, latency 5.
